sha_round: RTL and testbench
============================

Name: sha_round

Overview:
- SHA-256 compression engine for the bitcoin miner datapath.
- Sits directly upstream of sha_hash: takes chaining value H_i and one 512-bit message block, runs the 64 compression rounds (one round per clock), then presents working variables a..h plus the unchanged H_i.
- sha_hash adds these to form the block digest.
- Message schedule is generated on the fly from a 16-word sliding window; no 64-word W storage.

Parameters:
- none. Widths come from shared macros: `WORD_S=32, `H_SIZE=256, `VEC_I(i) = 32-bit slice i, slice 0 least significant.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk (0 = reset).
- en  in  1  start strobe; sampled only in IDLE.
- H_i  in  `H_SIZE  chaining value; H0 in `VEC_I(7), ..., H7 in `VEC_I(0).
- M  in  512  message block; W0 in bits [511:480], ..., W15 in bits [31:0].
- busy  out  1  high while a block is in flight.
- en_o  out  1  one-cycle pulse: a..h and H_o valid.
- H_o  out  `H_SIZE  copy of H_i latched at start; feeds sha_hash H_i.
- a, b, c, d, e, f, g, h  out  `WORD_S each  working variables; feed sha_hash a..h.

Behaviour:
- Reset (reset==0 at an edge):
  - state <= IDLE; busy, en_o <= 0.
  - a..h, H_o and the W window <= 0; round counter <= 0.
  - Overrides everything, including a block mid-round: the block is aborted and no en_o is produced.
- State machine: IDLE, ROUND.
- IDLE, en==1 at edge E0 (start):
  - a <= H_i[`VEC_I(7)], b <= `VEC_I(6), ..., h <= `VEC_I(0).
  - H_o <= H_i; window W[0..15] <= M words; t <= 0; busy <= 1; state <= ROUND.
- IDLE, en==0: all outputs hold; en_o <= 0.
- ROUND, at edges E1..E64 (t = 0..63):
  - Apply standard SHA-256 round t with W_t = W[0] and K_t.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K_t + W_t; T2 = Σ0(a) + Maj(a,b,c).
  - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - All additions are modulo 2^32; carries discarded.
  - Window shift: W[i] <= W[i+1]; W[15] <= σ1(W[14]) + W[9] + σ0(W[1]) + W[0] (mod 2^32).
  - Σ0 = ROTR2^13^22, Σ1 = ROTR6^11^25, σ0 = ROTR7^ROTR18^SHR3, σ1 = ROTR17^ROTR19^SHR10.
  - t increments each round; 6-bit counter, wraps to 0 after 63.
- At E64 (t==63): state <= IDLE, busy <= 0, en_o <= 1.
- en_o is low on every other edge: exactly one cycle wide.
- Latency: en_o high in the cycle following the 64th edge after the start edge (E0 + 64).
- a..h and H_o hold their final values after en_o until the next start. sha_hash samples them while en_o==1.
- en while busy: ignored; not queued; H_i/M changes are not observed.
- en held high continuously: the next start is sampled at E65. The block period is 65 cycles; en_o pulses are at E64, E129, ...
- H_i and M need only be stable at the start edge.

Decomposition:
- sha.vh (shared include) gains:
  - K-constant access;
  - ROTR/SHR and Σ0/Σ1/σ0/σ1/Ch/Maj as macros or functions;
  - word-index macro for M.
- Sub-module sha_k_rom: combinational 6-bit t -> 32-bit K_t (64-entry case).
- sha_round instantiates sha_k_rom; the round datapath stays in sha_round.

Test Plan:
- Known answer "abc": H_i = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19 (H0 in the MSB slice); M = 61626380, 14 zero words, 00000018.
  - en_o at E0+64.
  - a+H0..h+H7 (mod 2^32) = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - H_o == H_i.
- Known answer empty string: same H_i, M = 80000000 followed by 15 zero words.
  - Sums = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- en pulsed at E10 (mid-"abc" block) with a different M:
  - Ignored; "abc" result unchanged.
  - busy stays high through E64; exactly one en_o.
- en held high, two blocks back-to-back:
  - en_o at E64 and E129 only, each one cycle wide.
  - Second result correct.
  - Outputs stable between pulses.
- reset=0 at round 30 for one cycle:
  - Next cycle: busy=0, en_o=0, a..h=0, H_o=0; no en_o ever for the aborted block.
  - A fresh "abc" start afterwards gives the correct digest.
- Hookup with sha_hash (en_o -> en, H_o/a..h -> inputs): sha_hash H equals the "abc" digest one cycle after en_o.

Source files
------------

// File: rtl/sha_round_pkg.sv
// Shared SHA-256 types, widths and round helper functions for the sha_round datapath.
package sha_round_pkg;

  localparam int unsigned WORD_S  = 32;
  localparam int unsigned H_SIZE  = 256;
  localparam int unsigned M_SIZE  = 512;
  localparam int unsigned N_WORDS = 16;
  localparam int unsigned T_W     = 6;

  typedef logic [WORD_S-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_t;

  // Working variables a..h; a sits in the most significant slice, matching H0 in H_i.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_S - n));
  endfunction

  function automatic word_t shr(input word_t x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // 32-bit slice i of a chaining value, slice 0 least significant.
  function automatic word_t vec_i(input logic [H_SIZE-1:0] v, input int unsigned i);
    return v[i*WORD_S +: WORD_S];
  endfunction

  // Message word W_i; W0 occupies the top 32 bits of the block.
  function automatic word_t m_word(input logic [M_SIZE-1:0] m, input int unsigned i);
    return m[(N_WORDS-1-i)*WORD_S +: WORD_S];
  endfunction

endpackage

// File: rtl/sha_round_k_rom.sv
// Combinational SHA-256 round-constant table: round index t -> K_t.
module sha_k_rom
  import sha_round_pkg::*;
(
  input  logic [T_W-1:0]    t,
  output logic [WORD_S-1:0] k_c
);

  always_comb begin
    k_c = '0;
    case (t)
      6'd0:  k_c = 32'h428a2f98;
      6'd1:  k_c = 32'h71374491;
      6'd2:  k_c = 32'hb5c0fbcf;
      6'd3:  k_c = 32'he9b5dba5;
      6'd4:  k_c = 32'h3956c25b;
      6'd5:  k_c = 32'h59f111f1;
      6'd6:  k_c = 32'h923f82a4;
      6'd7:  k_c = 32'hab1c5ed5;
      6'd8:  k_c = 32'hd807aa98;
      6'd9:  k_c = 32'h12835b01;
      6'd10: k_c = 32'h243185be;
      6'd11: k_c = 32'h550c7dc3;
      6'd12: k_c = 32'h72be5d74;
      6'd13: k_c = 32'h80deb1fe;
      6'd14: k_c = 32'h9bdc06a7;
      6'd15: k_c = 32'hc19bf174;
      6'd16: k_c = 32'he49b69c1;
      6'd17: k_c = 32'hefbe4786;
      6'd18: k_c = 32'h0fc19dc6;
      6'd19: k_c = 32'h240ca1cc;
      6'd20: k_c = 32'h2de92c6f;
      6'd21: k_c = 32'h4a7484aa;
      6'd22: k_c = 32'h5cb0a9dc;
      6'd23: k_c = 32'h76f988da;
      6'd24: k_c = 32'h983e5152;
      6'd25: k_c = 32'ha831c66d;
      6'd26: k_c = 32'hb00327c8;
      6'd27: k_c = 32'hbf597fc7;
      6'd28: k_c = 32'hc6e00bf3;
      6'd29: k_c = 32'hd5a79147;
      6'd30: k_c = 32'h06ca6351;
      6'd31: k_c = 32'h14292967;
      6'd32: k_c = 32'h27b70a85;
      6'd33: k_c = 32'h2e1b2138;
      6'd34: k_c = 32'h4d2c6dfc;
      6'd35: k_c = 32'h53380d13;
      6'd36: k_c = 32'h650a7354;
      6'd37: k_c = 32'h766a0abb;
      6'd38: k_c = 32'h81c2c92e;
      6'd39: k_c = 32'h92722c85;
      6'd40: k_c = 32'ha2bfe8a1;
      6'd41: k_c = 32'ha81a664b;
      6'd42: k_c = 32'hc24b8b70;
      6'd43: k_c = 32'hc76c51a3;
      6'd44: k_c = 32'hd192e819;
      6'd45: k_c = 32'hd6990624;
      6'd46: k_c = 32'hf40e3585;
      6'd47: k_c = 32'h106aa070;
      6'd48: k_c = 32'h19a4c116;
      6'd49: k_c = 32'h1e376c08;
      6'd50: k_c = 32'h2748774c;
      6'd51: k_c = 32'h34b0bcb5;
      6'd52: k_c = 32'h391c0cb3;
      6'd53: k_c = 32'h4ed8aa4a;
      6'd54: k_c = 32'h5b9cca4f;
      6'd55: k_c = 32'h682e6ff3;
      6'd56: k_c = 32'h748f82ee;
      6'd57: k_c = 32'h78a5636f;
      6'd58: k_c = 32'h84c87814;
      6'd59: k_c = 32'h8cc70208;
      6'd60: k_c = 32'h90befffa;
      6'd61: k_c = 32'ha4506ceb;
      6'd62: k_c = 32'hbef9a3f7;
      6'd63: k_c = 32'hc67178f2;
      default: k_c = '0;
    endcase
  end

endmodule

// File: rtl/sha_round.sv
// SHA-256 compression engine: 64 rounds at one per clock with an on-the-fly
// 16-word message schedule window; presents a..h and the latched H_i for sha_hash.
module sha_round
  import sha_round_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [H_SIZE-1:0] H_i,
  input  logic [M_SIZE-1:0] M,
  output logic              busy,
  output logic              en_o,
  output logic [H_SIZE-1:0] H_o,
  output logic [WORD_S-1:0] a,
  output logic [WORD_S-1:0] b,
  output logic [WORD_S-1:0] c,
  output logic [WORD_S-1:0] d,
  output logic [WORD_S-1:0] e,
  output logic [WORD_S-1:0] f,
  output logic [WORD_S-1:0] g,
  output logic [WORD_S-1:0] h
);

  state_t            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  work_t             work_q, work_d;
  word_t             w_q [N_WORDS];
  word_t             w_d [N_WORDS];
  logic [H_SIZE-1:0] h_o_q, h_o_d;
  logic              busy_q, busy_d;
  logic              en_o_q, en_o_d;

  word_t k_t;
  word_t t1;
  word_t t2;
  word_t w_new;

  sha_k_rom u_k_rom (
    .t   (t_q),
    .k_c (k_t)
  );

  // Round temporaries and the next schedule word, all modulo 2^32.
  assign t1    = work_q.h + big_sigma1(work_q.e) + ch(work_q.e, work_q.f, work_q.g) + k_t + w_q[0];
  assign t2    = big_sigma0(work_q.a) + maj(work_q.a, work_q.b, work_q.c);
  assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      work_q  <= '0;
      w_q     <= '{default: '0};
      h_o_q   <= '0;
      busy_q  <= 1'b0;
      en_o_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      work_q  <= work_d;
      w_q     <= w_d;
      h_o_q   <= h_o_d;
      busy_q  <= busy_d;
      en_o_q  <= en_o_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    work_d  = work_q;
    w_d     = w_q;
    h_o_d   = h_o_q;
    busy_d  = busy_q;
    en_o_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = ROUND;
          t_d     = '0;
          work_d  = work_t'(H_i);
          h_o_d   = H_i;
          busy_d  = 1'b1;
          for (int unsigned i = 0; i < N_WORDS; i++) begin
            w_d[i] = m_word(M, i);
          end
        end
      end

      ROUND: begin
        work_d.h = work_q.g;
        work_d.g = work_q.f;
        work_d.f = work_q.e;
        work_d.e = work_q.d + t1;
        work_d.d = work_q.c;
        work_d.c = work_q.b;
        work_d.b = work_q.a;
        work_d.a = t1 + t2;
        for (int unsigned i = 0; i < N_WORDS - 1; i++) begin
          w_d[i] = w_q[i+1];
        end
        w_d[N_WORDS-1] = w_new;
        t_d = t_q + T_W'(1);
        // Last round: hand the result to sha_hash with a single-cycle strobe.
        if (t_q == T_W'(63)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          en_o_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign en_o = en_o_q;
  assign H_o  = h_o_q;
  assign a    = work_q.a;
  assign b    = work_q.b;
  assign c    = work_q.c;
  assign d    = work_q.d;
  assign e    = work_q.e;
  assign f    = work_q.f;
  assign g    = work_q.g;
  assign h    = work_q.h;

endmodule

// File: tb/tb_sha_round.sv
// Directed known-answer bench for sha_round, including a behavioural sha_hash
// stage that adds H_o to a..h on en_o.
module tb_sha_round;

  localparam logic [255:0] H_INIT    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] M_ABC     = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_EMPTY   = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  typedef struct {
    logic [255:0] h_in;
    logic [511:0] m;
    logic [255:0] digest;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         en;
  logic [255:0] H_i;
  logic [511:0] M;
  logic         busy;
  logic         en_o;
  logic [255:0] H_o;
  logic [31:0]  a, b, c, d, e, f, g, h;

  logic [255:0] sum_c;
  logic [255:0] hash_q;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [2];

  sha_round dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .H_i   (H_i),
    .M     (M),
    .busy  (busy),
    .en_o  (en_o),
    .H_o   (H_o),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .h     (h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sum_c = {32'(a + H_o[255:224]), 32'(b + H_o[223:192]), 32'(c + H_o[191:160]),
                  32'(d + H_o[159:128]), 32'(e + H_o[127:96]),  32'(f + H_o[95:64]),
                  32'(g + H_o[63:32]),   32'(h + H_o[31:0])};

  // Downstream digest adder as sha_hash would see it.
  always_ff @(posedge clk) begin
    if (en_o) hash_q <= sum_c;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_digest(input string nm, input logic [255:0] exp);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s word %0d", nm, i), 256'(sum_c[(7-i)*32 +: 32]), 256'(exp[(7-i)*32 +: 32]));
    end
  endtask

  task automatic start_block(input logic [255:0] hv, input logic [511:0] mv);
    H_i = hv;
    M   = mv;
    en  = 1'b1;
    step();
    en  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (en_o !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int p1;
    int p2;
    int busy_bad;
    logic [255:0] held;

    vecs[0] = '{h_in: H_INIT, m: M_ABC,   digest: DIG_ABC};
    vecs[1] = '{h_in: H_INIT, m: M_EMPTY, digest: DIG_EMPTY};

    reset = 1'b0;
    en    = 1'b0;
    H_i   = '0;
    M     = '0;
    step();
    step();
    chk("reset busy", 256'(busy), 256'(0));
    chk("reset en_o", 256'(en_o), 256'(0));
    chk("reset a..h", {a, b, c, d, e, f, g, h}, 256'(0));
    chk("reset H_o", H_o, 256'(0));
    reset = 1'b1;
    step();

    // Known-answer vectors.
    for (int v = 0; v < 2; v++) begin
      start_block(vecs[v].h_in, vecs[v].m);
      chk($sformatf("v%0d busy after start", v), 256'(busy), 256'(1));
      wait_done(lat);
      chk($sformatf("v%0d latency", v), 256'(lat), 256'(64));
      chk($sformatf("v%0d busy at done", v), 256'(busy), 256'(0));
      check_digest($sformatf("v%0d digest", v), vecs[v].digest);
      chk($sformatf("v%0d H_o", v), H_o, vecs[v].h_in);
      held = {a, b, c, d, e, f, g, h};
      step();
      chk($sformatf("v%0d sha_hash", v), hash_q, vecs[v].digest);
      chk($sformatf("v%0d en_o width", v), 256'(en_o), 256'(0));
      step();
      step();
      chk($sformatf("v%0d hold a..h", v), {a, b, c, d, e, f, g, h}, held);
      chk($sformatf("v%0d hold en_o", v), 256'(en_o), 256'(0));
    end

    // en pulsed mid-block is ignored.
    start_block(H_INIT, M_ABC);
    for (int i = 1; i < 10; i++) step();
    H_i = 256'h0;
    M   = M_EMPTY;
    en  = 1'b1;
    step();
    en  = 1'b0;
    pulses = 0;
    p1 = 0;
    busy_bad = 0;
    for (int cyc = 11; cyc <= 80; cyc++) begin
      step();
      if (cyc < 64 && busy !== 1'b1) busy_bad++;
      if (en_o === 1'b1) begin
        pulses++;
        p1 = cyc;
      end
    end
    chk("ignore busy held", 256'(busy_bad), 256'(0));
    chk("ignore pulse count", 256'(pulses), 256'(1));
    chk("ignore pulse cycle", 256'(p1), 256'(64));
    check_digest("ignore digest", DIG_ABC);
    chk("ignore H_o", H_o, H_INIT);

    // en held high: back-to-back blocks.
    H_i = H_INIT;
    M   = M_ABC;
    en  = 1'b1;
    step();
    M   = M_EMPTY;
    pulses = 0;
    p1 = 0;
    p2 = 0;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      step();
      if (cyc == 65) en = 1'b0;
      if (en_o === 1'b1) begin
        pulses++;
        if (pulses == 1) p1 = cyc;
        else p2 = cyc;
        if (cyc == 64) check_digest("b2b first", DIG_ABC);
        if (cyc == 129) check_digest("b2b second", DIG_EMPTY);
      end
    end
    chk("b2b pulse count", 256'(pulses), 256'(2));
    chk("b2b first pulse", 256'(p1), 256'(64));
    chk("b2b second pulse", 256'(p2), 256'(129));

    // Reset mid-block aborts it.
    start_block(H_INIT, M_ABC);
    for (int i = 1; i <= 30; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort busy", 256'(busy), 256'(0));
    chk("abort en_o", 256'(en_o), 256'(0));
    chk("abort a..h", {a, b, c, d, e, f, g, h}, 256'(0));
    chk("abort H_o", H_o, 256'(0));
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (en_o === 1'b1) pulses++;
    end
    chk("abort no en_o", 256'(pulses), 256'(0));
    start_block(H_INIT, M_ABC);
    wait_done(lat);
    chk("after abort latency", 256'(lat), 256'(64));
    check_digest("after abort digest", DIG_ABC);
    step();
    chk("after abort sha_hash", hash_q, DIG_ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
